// File: rtl/data_cache_dm_pkg.sv
// Shared definitions for the direct-mapped data cache.
//   state_t         : controller state encoding
//   SM_BYTE/HALF/WORD: access-size codes carried in sign_mask[2:0]
//   LANE_W          : width of one byte lane
//   mask_is_legal() : true for the three supported size codes
package data_cache_dm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_DONE   = 3'd2,
        ST_WBACK  = 3'd3,
        ST_REFILL = 3'd4
    } state_t;

    localparam logic [2:0] SM_BYTE = 3'b001;
    localparam logic [2:0] SM_HALF = 3'b011;
    localparam logic [2:0] SM_WORD = 3'b111;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned NUM_LANES = 4;

    function automatic logic mask_is_legal(input logic [2:0] size);
        return (size == SM_BYTE) || (size == SM_HALF) || (size == SM_WORD);
    endfunction

endpackage

// File: rtl/data_cache_dm_lane_mux.sv
// Byte-lane steering for the data cache (purely combinational).
//   word_i     : addressed line word from the data array
//   wdata_i    : right-aligned store data
//   byte_off_i : byte offset within the word (addr[1:0])
//   mask_i     : [2:0] access size, [3] sign-extend on load
//   rdata_o    : extracted, extended load value (0 for an illegal size)
//   mdata_o    : word_i with the store lanes replaced (unchanged for an illegal size)
//   legal_o    : size code is one of byte/half/word
module data_cache_dm_lane_mux
    import data_cache_dm_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  byte_off_i,
    input  logic [3:0]  mask_i,
    output logic [31:0] rdata_o,
    output logic [31:0] mdata_o,
    output logic        legal_o
);

    logic [4:0]  shamt;
    logic [31:0] lane_bits;
    logic [31:0] word_sh;
    logic [31:0] be_bits;
    logic        msb;

    always_comb begin
        shamt     = '0;
        lane_bits = '0;
        msb       = 1'b0;
        legal_o   = mask_is_legal(mask_i[2:0]);

        case (mask_i[2:0])
            SM_BYTE: begin
                shamt     = {byte_off_i, 3'b000};
                lane_bits = 32'h0000_00FF;
            end
            SM_HALF: begin
                // Halfword uses the aligned lane pair; addr[0] is ignored.
                shamt     = {byte_off_i[1], 4'b0000};
                lane_bits = 32'h0000_FFFF;
            end
            SM_WORD: begin
                shamt     = '0;
                lane_bits = 32'hFFFF_FFFF;
            end
            default: begin
                shamt     = '0;
                lane_bits = '0;
            end
        endcase

        word_sh = word_i >> shamt;
        msb     = (mask_i[2:0] == SM_BYTE) ? word_sh[LANE_W-1] : word_sh[2*LANE_W-1];

        // For a full word ~lane_bits is zero, so the extension term drops out.
        if (legal_o) begin
            rdata_o = (word_sh & lane_bits) | ({32{mask_i[3] & msb}} & ~lane_bits);
        end else begin
            rdata_o = '0;
        end

        be_bits = lane_bits << shamt;
        mdata_o = (word_i & ~be_bits) | ((wdata_i << shamt) & be_bits);
    end

endmodule

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with an uncached LED register.
//   clk, reset_n          : clock and synchronous active-low reset
//   addr, write_data      : core byte address and right-aligned store data
//   memread, memwrite     : load / store request (load wins if both)
//   sign_mask             : [2:0] size code, [3] sign-extend loads
//   read_data             : load result, valid once clk_stall drops
//   clk_stall             : hold the core pipeline
//   led                   : LED register
//   mem_req/we/addr/wdata : backing-memory beat request (word address, DMEM_BASE removed)
//   mem_ack, mem_rdata    : beat completion and refill data
//
// state  | meaning
// IDLE   | waiting for a request; LED writes handled here
// LOOKUP | tag compare on the registered request
// DONE   | hit: load result / store merge, stall released on exit
// WBACK  | writing the dirty victim line, word 0 first
// REFILL | reading the requested line, word 0 first, then replay LOOKUP
module data_cache_dm
    import data_cache_dm_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] DMEM_BASE  = 32'h1000,
    parameter logic [31:0] LED_ADDR   = 32'h2000
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic [7:0]  led,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS);
    localparam int unsigned BEAT_W    = (OFF_W > 0) ? OFF_W : 1;
    localparam int unsigned TAG_W     = 30 - OFF_W - IDX_W;
    localparam int unsigned RAM_DEPTH = NUM_LINES * LINE_WORDS;
    localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_t state_q, state_d;

    logic [31:0]       req_off_q;
    logic [31:0]       req_wdata_q;
    logic [3:0]        req_mask_q;
    logic              req_write_q;
    logic [BEAT_W-1:0] beat_q;
    logic [31:0]       read_data_q;
    logic [7:0]        led_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    logic [31:0]      data_mem [RAM_DEPTH];
    logic [TAG_W-1:0] tag_mem  [NUM_LINES];

    logic [BEAT_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              victim_dirty;
    logic              last_beat;
    logic              start_req;
    logic              led_wr;
    logic [31:0]       line_word;
    logic [31:0]       lane_rdata;
    logic [31:0]       lane_mdata;
    logic              mask_legal;

    function automatic logic [RAM_AW-1:0] ram_addr(input logic [IDX_W-1:0]  idx,
                                                   input logic [BEAT_W-1:0] word);
        return RAM_AW'(32'(idx) * LINE_WORDS + (32'(word) & 32'(LINE_WORDS - 1)));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [TAG_W-1:0]  tag,
                                              input logic [IDX_W-1:0]  idx,
                                              input logic [BEAT_W-1:0] beat);
        return (32'(tag) << (OFF_W + IDX_W)) | (32'(idx) << OFF_W)
             | (32'(beat) & 32'(LINE_WORDS - 1));
    endfunction

    // Field split of the DMEM_BASE-relative request address.
    assign req_word = BEAT_W'((req_off_q >> 2) & 32'(LINE_WORDS - 1));
    assign req_idx  = IDX_W'(req_off_q >> (2 + OFF_W));
    assign req_tag  = TAG_W'(req_off_q >> (2 + OFF_W + IDX_W));

    assign hit          = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
    assign last_beat    = (beat_q == LAST_BEAT);
    assign line_word    = data_mem[ram_addr(req_idx, req_word)];

    assign start_req = memread || (memwrite && (addr != LED_ADDR));
    assign led_wr    = !memread && memwrite && (addr == LED_ADDR);

    data_cache_dm_lane_mux u_lane_mux (
        .word_i     (line_word),
        .wdata_i    (req_wdata_q),
        .byte_off_i (req_off_q[1:0]),
        .mask_i     (req_mask_q),
        .rdata_o    (lane_rdata),
        .mdata_o    (lane_mdata),
        .legal_o    (mask_legal)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    state_d = ST_DONE;
                end else if (victim_dirty) begin
                    state_d = ST_WBACK;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_WBACK: begin
                if (mem_ack && last_beat) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                // Replay the lookup so loads and stores share the hit path.
                if (mem_ack && last_beat) begin
                    state_d = ST_LOOKUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        clk_stall = (state_q != ST_IDLE);
        mem_req   = (state_q == ST_WBACK) || (state_q == ST_REFILL);
        mem_we    = (state_q == ST_WBACK);
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_WBACK: begin
                mem_addr  = beat_addr(tag_mem[req_idx], req_idx, beat_q);
                mem_wdata = data_mem[ram_addr(req_idx, beat_q)];
            end
            ST_REFILL: begin
                mem_addr = beat_addr(req_tag, req_idx, beat_q);
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

    // Request capture, beat counter, line status, result and LED registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_off_q   <= '0;
            req_wdata_q <= '0;
            req_mask_q  <= '0;
            req_write_q <= 1'b0;
            beat_q      <= '0;
            read_data_q <= '0;
            led_q       <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    beat_q <= '0;
                    if (start_req) begin
                        req_off_q   <= addr - DMEM_BASE;
                        req_wdata_q <= write_data;
                        req_mask_q  <= sign_mask;
                        req_write_q <= !memread;
                    end else if (led_wr) begin
                        led_q <= write_data[7:0];
                    end
                end
                ST_WBACK, ST_REFILL: begin
                    if (mem_ack) begin
                        beat_q <= last_beat ? '0 : beat_q + 1'b1;
                        if ((state_q == ST_REFILL) && last_beat) begin
                            valid_q[req_idx] <= 1'b1;
                            dirty_q[req_idx] <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (!mask_legal) begin
                        read_data_q <= '0;
                    end else if (!req_write_q) begin
                        read_data_q <= lane_rdata;
                    end else begin
                        dirty_q[req_idx] <= 1'b1;
                    end
                end
                default: begin
                    beat_q <= beat_q;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid_q guards their contents.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if ((state_q == ST_REFILL) && mem_ack) begin
                data_mem[ram_addr(req_idx, beat_q)] <= mem_rdata;
                if (last_beat) begin
                    tag_mem[req_idx] <= req_tag;
                end
            end
            if ((state_q == ST_DONE) && req_write_q && mask_legal) begin
                data_mem[ram_addr(req_idx, req_word)] <= lane_mdata;
            end
        end
    end

    assign read_data = read_data_q;
    assign led       = led_q;

endmodule

// File: tb/tb_data_cache_dm.sv
module tb_data_cache_dm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = '0;
    logic [31:0] read_data;
    logic        clk_stall;
    logic [7:0]  led;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    data_cache_dm #(
        .NUM_LINES  (64),
        .LINE_WORDS (4),
        .DMEM_BASE  (32'h1000),
        .LED_ADDR   (32'h2000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .clk_stall  (clk_stall),
        .led        (led),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    // Backing memory: acks each beat one cycle after the request is seen.
    logic [31:0] mem_model [1024];
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    logic [31:0] rd_addr_log [$];

    assign mem_rdata = mem_model[mem_addr % 1024];

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                mem_model[mem_addr % 1024] = mem_wdata;
                wr_addr_log.push_back(mem_addr);
                wr_data_log.push_back(mem_wdata);
                n_wr = n_wr + 1;
            end else begin
                rd_addr_log.push_back(mem_addr);
                n_rd = n_rd + 1;
            end
        end
        mem_ack <= mem_req && !mem_ack;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One core access; checks stall length, mem_req cycles and beat counts.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic [3:0] m,
                        input int exp_stall, input int exp_req, input int exp_rds, input int exp_wrs);
        int rd0, wr0, stall, req;
        @(negedge clk);
        rd0 = n_rd;
        wr0 = n_wr;
        addr = a; write_data = wd; memread = rd; memwrite = wr; sign_mask = m;
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0;
        stall = 0; req = 0;
        while (clk_stall && stall < 500) begin
            stall++;
            if (mem_req) req++;
            @(negedge clk);
        end
        chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        chk({tag, ".req"},   32'(req),   32'(exp_req));
        chk({tag, ".rds"},   32'(n_rd - rd0), 32'(exp_rds));
        chk({tag, ".wrs"},   32'(n_wr - wr0), 32'(exp_wrs));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'hA500_0000 | 32'(i);
        mem_model[0]     = 32'hDEAD_BEEF;
        mem_model[1]     = 32'h1122_3344;
        mem_model[10'h100] = 32'hCAFE_F00D;
        mem_model[10'h200] = 32'h0BAD_C0DE;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.stall", 32'(clk_stall), 32'd0);
        chk("rst.req",   32'(mem_req),   32'd0);
        chk("rst.we",    32'(mem_we),    32'd0);
        chk("rst.rdata", read_data,      32'd0);
        chk("rst.led",   32'(led),       32'd0);
        reset_n = 1'b1;

        // Cold miss, clean: 4 read beats of 2 cycles each.
        xfer("cold_lw", 32'h1000, 0, 1, 0, 4'b0111, 11, 8, 4, 0);
        chk("cold_lw.data", read_data, 32'hDEAD_BEEF);
        chk("cold_lw.rd0",  rd_addr_log[0], 32'h0);
        chk("cold_lw.rd3",  rd_addr_log[3], 32'h3);

        xfer("hit_lw", 32'h1004, 0, 1, 0, 4'b0111, 2, 0, 0, 0);
        chk("hit_lw.data", read_data, 32'h1122_3344);

        xfer("sb", 32'h1001, 32'h0000_0080, 0, 1, 4'b0001, 2, 0, 0, 0);
        xfer("lb", 32'h1001, 0, 1, 0, 4'b1001, 2, 0, 0, 0);
        chk("lb.data", read_data, 32'hFFFF_FF80);
        xfer("lbu", 32'h1001, 0, 1, 0, 4'b0001, 2, 0, 0, 0);
        chk("lbu.data", read_data, 32'h0000_0080);
        xfer("lw_merged", 32'h1000, 0, 1, 0, 4'b0111, 2, 0, 0, 0);
        chk("lw_merged.data", read_data, 32'hDEAD_80EF);
        xfer("lh", 32'h1002, 0, 1, 0, 4'b1011, 2, 0, 0, 0);
        chk("lh.data", read_data, 32'hFFFF_DEAD);
        xfer("lhu", 32'h1003, 0, 1, 0, 4'b0011, 2, 0, 0, 0);
        chk("lhu.data", read_data, 32'h0000_DEAD);
        xfer("sh", 32'h1006, 32'h0000_BEEF, 0, 1, 4'b0011, 2, 0, 0, 0);
        xfer("lw_sh", 32'h1004, 0, 1, 0, 4'b0111, 2, 0, 0, 0);
        chk("lw_sh.data", read_data, 32'hBEEF_3344);

        xfer("ill_ld", 32'h1000, 0, 1, 0, 4'b0101, 2, 0, 0, 0);
        chk("ill_ld.data", read_data, 32'h0);
        xfer("ill_st", 32'h1000, 32'hFFFF_FFFF, 0, 1, 4'b0100, 2, 0, 0, 0);
        xfer("ill_chk", 32'h1000, 0, 1, 0, 4'b0111, 2, 0, 0, 0);
        chk("ill_chk.data", read_data, 32'hDEAD_80EF);

        // LED write: no stall, no memory traffic, cache left alone.
        @(negedge clk);
        addr = 32'h2000; write_data = 32'h0000_00A5; memwrite = 1'b1; sign_mask = 4'b0111;
        @(negedge clk);
        memwrite = 1'b0;
        chk("led.val",   32'(led),       32'hA5);
        chk("led.stall", 32'(clk_stall), 32'd0);
        chk("led.req",   32'(mem_req),   32'd0);
        xfer("led_after", 32'h1000, 0, 1, 0, 4'b0111, 2, 0, 0, 0);
        chk("led_after.data", read_data, 32'hDEAD_80EF);

        // Dirty victim: 4 writebacks then 4 refills.
        xfer("alias", 32'h1400, 0, 1, 0, 4'b0111, 19, 16, 4, 4);
        chk("alias.data", read_data, 32'hCAFE_F00D);
        chk("alias.wa0", wr_addr_log[0], 32'h0);
        chk("alias.wd0", wr_data_log[0], 32'hDEAD_80EF);
        chk("alias.wd1", wr_data_log[1], 32'hBEEF_3344);
        chk("alias.wd3", wr_data_log[3], 32'hA500_0003);
        chk("alias.wa3", wr_addr_log[3], 32'h3);
        chk("alias.ra0", rd_addr_log[4], 32'h100);
        chk("alias.ra3", rd_addr_log[7], 32'h103);

        xfer("back", 32'h1004, 0, 1, 0, 4'b0111, 11, 8, 4, 0);
        chk("back.data", read_data, 32'hBEEF_3344);

        // Reset in the middle of a refill.
        @(negedge clk);
        guard = n_rd;
        addr = 32'h1800; memread = 1'b1; sign_mask = 4'b0111;
        @(negedge clk);
        memread = 1'b0;
        begin
            int w = 0;
            while ((n_rd - guard) < 2 && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk("midrst.reach", 32'(w < 100), 32'd1);
        end
        chk("midrst.pre_req", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst.req",   32'(mem_req),   32'd0);
        chk("midrst.stall", 32'(clk_stall), 32'd0);
        chk("midrst.rdata", read_data,      32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        xfer("reload", 32'h1800, 0, 1, 0, 4'b0111, 11, 8, 4, 0);
        chk("reload.data", read_data, 32'h0BAD_C0DE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
